easyaxi_slv_wr_ctrl: RTL and testbench

AXI slave write controller; consumes the AW/W channels driven by the master write controller and returns B responses. It removes the tied-high awready/wready in the top level and completes the write path alongside the slave read controller. Internal flop-based word memory is written per beat, and a combinational debug read port exposes it to the bench. One outstanding transaction at a time.

---
 rtl/easyaxi_slv_wr_ctrl_pkg.sv | 14 +
 rtl/easyaxi_slv_wr_ctrl_if.sv | 38 +++
 rtl/easyaxi_axi_addr_gen.sv | 23 ++
 rtl/easyaxi_slv_wr_ctrl.sv | 99 +++++++++
 tb/tb_easyaxi_slv_wr_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/easyaxi_slv_wr_ctrl_pkg.sv
// easyaxi_slv_wr_ctrl_pkg: shared AXI widths, burst/resp encodings and slave write FSM states.
package easyaxi_slv_wr_ctrl_pkg;
   localparam int AXI_ID_W    = 4;
   localparam int AXI_ADDR_W  = 32;
   localparam int AXI_LEN_W   = 8;
   localparam int AXI_SIZE_W  = 3;
   localparam int AXI_BURST_W = 2;
   localparam int AXI_USER_W  = 4;
   localparam int AXI_DATA_W  = 64;
   localparam int AXI_RESP_W  = 2;
   typedef enum logic [1:0] {BURST_FIXED = 2'd0, BURST_INCR = 2'd1, BURST_WRAP = 2'd2} burst_e;
   typedef enum logic [1:0] {RESP_OKAY = 2'd0, RESP_SLVERR = 2'd2} resp_e;
   typedef enum logic [1:0] {IDLE = 2'd0, WDATA = 2'd1, BRESP = 2'd2} state_e;
endpackage

// File: rtl/easyaxi_slv_wr_ctrl_if.sv
// easyaxi_slv_wr_ctrl_if: AXI AW/W/B channel bundle with master and slave views.
interface easyaxi_slv_wr_ctrl_if
   import easyaxi_slv_wr_ctrl_pkg::*;
#(
   parameter int ID_W    = AXI_ID_W,
   parameter int ADDR_W  = AXI_ADDR_W,
   parameter int LEN_W   = AXI_LEN_W,
   parameter int SIZE_W  = AXI_SIZE_W,
   parameter int BURST_W = AXI_BURST_W,
   parameter int USER_W  = AXI_USER_W,
   parameter int DATA_W  = AXI_DATA_W
);
   logic                  awvalid, awready;
   logic [ID_W-1:0]       awid;
   logic [ADDR_W-1:0]     awaddr;
   logic [LEN_W-1:0]      awlen;
   logic [SIZE_W-1:0]     awsize;
   logic [BURST_W-1:0]    awburst;
   logic [USER_W-1:0]     awuser;
   logic                  wvalid, wready, wlast;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic [USER_W-1:0]     wuser;
   logic                  bvalid, bready;
   logic [ID_W-1:0]       bid;
   logic [AXI_RESP_W-1:0] bresp;
   logic [USER_W-1:0]     buser;
   modport mst (
      output awvalid, awid, awaddr, awlen, awsize, awburst, awuser,
      output wvalid, wdata, wstrb, wlast, wuser, bready,
      input  awready, wready, bvalid, bid, bresp, buser
   );
   modport slv (
      input  awvalid, awid, awaddr, awlen, awsize, awburst, awuser,
      input  wvalid, wdata, wstrb, wlast, wuser, bready,
      output awready, wready, bvalid, bid, bresp, buser
   );
endinterface

// File: rtl/easyaxi_axi_addr_gen.sv
// easyaxi_axi_addr_gen: combinational next-beat address for FIXED/INCR/WRAP bursts.
module easyaxi_axi_addr_gen
   import easyaxi_slv_wr_ctrl_pkg::*;
#(
   parameter int ADDR_W  = AXI_ADDR_W,
   parameter int LEN_W   = AXI_LEN_W,
   parameter int SIZE_W  = AXI_SIZE_W,
   parameter int BURST_W = AXI_BURST_W
) (
   input  logic [ADDR_W-1:0]  addr,
   input  logic [SIZE_W-1:0]  size,
   input  logic [LEN_W-1:0]   len,
   input  logic [BURST_W-1:0] burst,
   output logic [ADDR_W-1:0]  next_addr
);
   logic [ADDR_W-1:0] inc, mask;
   assign inc  = ADDR_W'(1) << size;
   // wrap boundary is (len+1)*inc, always a power of two for legal WRAP lengths
   assign mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
   always_comb
      next_addr = burst == BURST_FIXED ? addr :
                  burst == BURST_WRAP  ? (addr & ~mask) | ((addr + inc) & mask) : addr + inc;
endmodule

// File: rtl/easyaxi_slv_wr_ctrl.sv
// easyaxi_slv_wr_ctrl: AXI slave write controller with flop memory and debug read port.
// EASYAXI_SLV_WR_STRB_EN: honour wstrb per byte lane; otherwise every written beat stores the full word.
module easyaxi_slv_wr_ctrl
   import easyaxi_slv_wr_ctrl_pkg::*;
#(
   parameter int ID_W      = AXI_ID_W,
   parameter int ADDR_W    = AXI_ADDR_W,
   parameter int LEN_W     = AXI_LEN_W,
   parameter int SIZE_W    = AXI_SIZE_W,
   parameter int BURST_W   = AXI_BURST_W,
   parameter int USER_W    = AXI_USER_W,
   parameter int DATA_W    = AXI_DATA_W,
   parameter int MEM_DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   easyaxi_slv_wr_ctrl_if.slv           axi,
   input  logic [$clog2(MEM_DEPTH)-1:0] dbg_raddr,
   output logic [DATA_W-1:0]            dbg_rdata
);
   localparam int BYTES = DATA_W / 8;
   localparam int OFF   = $clog2(BYTES);
   localparam int IDX_W = $clog2(MEM_DEPTH);
   state_e             state;
   logic               init, err, aw_hs, w_hs, b_hs, in_range, wr_en, cfg_err, last_ok;
   logic [LEN_W-1:0]   beat_cnt, len;
   logic [ADDR_W-1:0]  addr, next_addr;
   logic [SIZE_W-1:0]  size;
   logic [BURST_W-1:0] burst;
   logic [ID_W-1:0]    id;
   logic [USER_W-1:0]  user;
   logic [IDX_W-1:0]   widx;
   logic [DATA_W-1:0]  mem [MEM_DEPTH];
   assign axi.awready = state == IDLE && init;
   assign axi.wready  = state == WDATA;
   assign axi.bvalid  = state == BRESP;
   assign axi.bid     = id;
   assign axi.buser   = user;
   assign axi.bresp   = err ? RESP_SLVERR : RESP_OKAY;
   assign aw_hs    = axi.awvalid && axi.awready;
   assign w_hs     = axi.wvalid && axi.wready;
   assign b_hs     = axi.bvalid && axi.bready;
   assign in_range = addr < ADDR_W'(MEM_DEPTH * BYTES);
   assign widx     = addr[OFF +: IDX_W];
   assign wr_en    = w_hs && in_range && !err && beat_cnt <= len;
   assign last_ok  = axi.wlast == (beat_cnt == len);
   assign cfg_err  = axi.awsize > SIZE_W'(OFF) || axi.awburst == BURST_W'(3) ||
                     (axi.awburst == BURST_WRAP && !(axi.awlen inside {LEN_W'(1), LEN_W'(3), LEN_W'(7), LEN_W'(15)}));
   assign dbg_rdata = mem[dbg_raddr];
   easyaxi_axi_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .SIZE_W(SIZE_W), .BURST_W(BURST_W)) u_addr_gen (
      .addr(addr), .size(size), .len(len), .burst(burst), .next_addr(next_addr)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         init     <= 1'b0;
         err      <= 1'b0;
         beat_cnt <= '0;
         len      <= '0;
         addr     <= '0;
         size     <= '0;
         burst    <= '0;
         id       <= '0;
         user     <= '0;
      end else begin
         init <= 1'b1;
         case (state)
            IDLE: if (aw_hs) begin
               state    <= WDATA;
               id       <= axi.awid;
               addr     <= axi.awaddr;
               len      <= axi.awlen;
               size     <= axi.awsize;
               burst    <= axi.awburst;
               user     <= axi.awuser;
               beat_cnt <= '0;
               err      <= cfg_err;
            end
            WDATA: if (w_hs) begin
               addr <= next_addr;
               err  <= err | !in_range | !last_ok;
               if (~&beat_cnt) beat_cnt <= beat_cnt + LEN_W'(1);
               if (axi.wlast) state <= BRESP;
            end
            BRESP: if (b_hs) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
`ifdef EASYAXI_SLV_WR_STRB_EN
         for (int b = 0; b < BYTES; b++) if (axi.wstrb[b]) mem[widx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
`else
         mem[widx] <= axi.wdata;
`endif
      end
endmodule

// File: tb/tb_easyaxi_slv_wr_ctrl.sv
// tb_easyaxi_slv_wr_ctrl: directed plus randomized bursts checked against a behavioural memory model.
`timescale 1ns/1ps
module tb_easyaxi_slv_wr_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  dbg_raddr = '0;
   logic [63:0] dbg_rdata;
   easyaxi_slv_wr_ctrl_if axi ();
   easyaxi_slv_wr_ctrl dut (.clk(clk), .rst_n(rst_n), .axi(axi.slv), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata));
   always #5 clk = ~clk;
   int          n_tests = 0, n_fail = 0;
   logic [63:0] ref_mem [16];
   logic [63:0] dq [32];
   logic [7:0]  sq [32];
   logic [1:0]  last_bresp;
   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic longint nxt(longint a, int size, int len, int burst);
      longint inc = longint'(1) << size;
      longint bnd = (len + 1) * inc;
      if (burst == 0) return a;
      if (burst == 2) return (a - a % bnd) + (a + inc) % bnd;
      return (a + inc) % (longint'(1) << 32);
   endfunction
   task automatic chk_mem(string tag);
      for (int i = 0; i < 16; i++) begin
         dbg_raddr = 4'(i);
         #1;
         chk($sformatf("%s_w%0d", tag, i), dbg_rdata, ref_mem[i]);
      end
      @(posedge clk); #1;
   endtask
   task automatic model(int addr, int len, int size, int burst, int nb);
      longint a = addr;
      bit     err = size > 3 || burst == 3 || (burst == 2 && !(len inside {1, 3, 7, 15}));
      for (int i = 0; i < nb; i++) begin
         int cnt = i > 255 ? 255 : i;
         if (a >= 128) err = 1;
         else if (!err && cnt <= len) begin
`ifdef EASYAXI_SLV_WR_STRB_EN
            for (int b = 0; b < 8; b++) if (sq[i][b]) ref_mem[a/8][b*8 +: 8] = dq[i][b*8 +: 8];
`else
            ref_mem[a/8] = dq[i];
`endif
         end
         if ((i == nb - 1) != (cnt == len)) err = 1;
         a = nxt(a, size, len, burst);
      end
      last_bresp = err ? 2'd2 : 2'd0;
   endtask
   task automatic run_txn(int id, int addr, int len, int size, int burst, int user, int nb, int bdelay);
      logic [1:0] exp_resp;
      model(addr, len, size, burst, nb);
      exp_resp = last_bresp;
      axi.awid = 4'(id); axi.awaddr = 32'(addr); axi.awlen = 8'(len);
      axi.awsize = 3'(size); axi.awburst = 2'(burst); axi.awuser = 4'(user);
      axi.awvalid = 1'b1;
      for (int c = 0; c < 50 && !axi.awready; c++) begin @(posedge clk); #1; end
      chk("awready_wait", axi.awready, 1);
      @(posedge clk); #1;
      axi.awvalid = 1'b0;
      chk("wready_lat", axi.wready, 1);
      for (int i = 0; i < nb; i++) begin
         axi.wvalid = 1'b1; axi.wdata = dq[i]; axi.wstrb = sq[i]; axi.wlast = i == nb - 1;
         axi.wuser = 4'($urandom);
         for (int c = 0; c < 50 && !axi.wready; c++) begin @(posedge clk); #1; end
         if (!axi.wready) chk("wready_wait", axi.wready, 1);
         @(posedge clk); #1;
         axi.wvalid = 1'b0; axi.wlast = 1'b0;
      end
      chk("bvalid_lat", axi.bvalid, 1);
      chk("wready_off", axi.wready, 0);
      for (int d = 0; d < bdelay; d++) begin
         @(posedge clk); #1;
         chk("bvalid_hold", axi.bvalid, 1);
         chk("bid_hold", axi.bid, 64'(id % 16));
         chk("bresp_hold", axi.bresp, exp_resp);
      end
      chk("bid", axi.bid, 64'(id % 16));
      chk("buser", axi.buser, 64'(user % 16));
      chk("bresp", axi.bresp, exp_resp);
      last_bresp = axi.bresp;
      axi.bready = 1'b1;
      @(posedge clk); #1;
      axi.bready = 1'b0;
      chk("bvalid_drop", axi.bvalid, 0);
      chk("awready_back", axi.awready, 1);
      chk_mem("mem");
   endtask
   task automatic chk_idle_outputs(string tag);
      chk({tag, "_awready"}, axi.awready, 0);
      chk({tag, "_wready"}, axi.wready, 0);
      chk({tag, "_bvalid"}, axi.bvalid, 0);
      chk({tag, "_bid"}, axi.bid, 0);
      chk({tag, "_bresp"}, axi.bresp, 0);
      chk({tag, "_buser"}, axi.buser, 0);
   endtask
   initial begin
      axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0;
      axi.awburst = 0; axi.awuser = 0; axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0;
      axi.wlast = 0; axi.wuser = 0; axi.bready = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_idle_outputs("rst");
      chk_mem("rst_mem");
      rst_n = 1'b1;
      chk("init_pre", axi.awready, 0);
      @(posedge clk); #1;
      chk("init_awready", axi.awready, 1);
      dq[0] = 64'h1122334455667788; sq[0] = 8'hFF;
      run_txn(5, 8, 0, 3, 1, 9, 1, 0);
      dbg_raddr = 4'd1; #1;
      chk("single_w1", dbg_rdata, 64'h1122334455667788);
      chk("single_resp", last_bresp, 0);
      for (int i = 0; i < 4; i++) begin dq[i] = 64'(i + 1); sq[i] = 8'hFF; end
      run_txn(3, 0, 3, 3, 1, 2, 4, 3);
      for (int i = 0; i < 4; i++) begin
         dbg_raddr = 4'(i); #1;
         chk("incr4", dbg_rdata, 64'(i + 1));
      end
      dq[0] = 64'hA; dq[1] = 64'hB; dq[2] = 64'hC; dq[3] = 64'hD;
      run_txn(7, 24, 3, 3, 2, 1, 4, 1);
      dbg_raddr = 4'd3; #1; chk("wrap_w3", dbg_rdata, 64'hA);
      dbg_raddr = 4'd0; #1; chk("wrap_w0", dbg_rdata, 64'hB);
      dbg_raddr = 4'd1; #1; chk("wrap_w1", dbg_rdata, 64'hC);
      dbg_raddr = 4'd2; #1; chk("wrap_w2", dbg_rdata, 64'hD);
      chk("wrap_resp", last_bresp, 0);
      dq[0] = '1; sq[0] = 8'hFF;
      run_txn(1, 128, 0, 3, 1, 0, 1, 0);
      chk("oor_resp", last_bresp, 2);
      run_txn(2, 0, 0, 3, 3, 0, 1, 0);
      chk("burst3_resp", last_bresp, 2);
      dq[0] = 64'h55; dq[1] = 64'h66;
      run_txn(4, 64, 1, 3, 1, 0, 1, 0);
      chk("early_last_resp", last_bresp, 2);
      dq[0] = '0; sq[0] = 8'hFF;
      run_txn(0, 0, 0, 3, 1, 0, 1, 0);
      dq[0] = '1; sq[0] = 8'h0F;
      run_txn(0, 0, 0, 3, 1, 0, 1, 0);
      dbg_raddr = 4'd0; #1;
`ifdef EASYAXI_SLV_WR_STRB_EN
      chk("strb_w0", dbg_rdata, 64'h00000000FFFFFFFF);
`else
      chk("strb_w0", dbg_rdata, 64'hFFFFFFFFFFFFFFFF);
`endif
      @(posedge clk); #1;
      for (int t = 0; t < 40; t++) begin
         int len, size, burst, nb, addr, k;
         burst = $urandom_range(0, 19) == 0 ? 3 : int'($urandom_range(0, 2));
         len   = burst == 2 ? ($urandom_range(0, 5) == 0 ? 2 : (1 << $urandom_range(1, 3)) - 1)
                            : int'($urandom_range(0, 7));
         size  = $urandom_range(0, 9) == 0 ? 4 : int'($urandom_range(0, 3));
         addr  = $urandom_range(0, 9) == 0 ? int'($urandom_range(128, 255)) : int'($urandom_range(0, 127));
         k     = $urandom_range(0, 9);
         nb    = (k == 0 && len > 0) ? len : k == 1 ? len + 2 : len + 1;
         for (int i = 0; i < nb; i++) begin
            dq[i] = {$urandom, $urandom};
            sq[i] = 8'($urandom);
         end
         run_txn(int'($urandom_range(0, 15)), addr, len, size, burst, int'($urandom_range(0, 15)), nb,
                 int'($urandom_range(0, 3)));
      end
      for (int i = 0; i < 4; i++) begin dq[i] = 64'hF0F0 + 64'(i); sq[i] = 8'hFF; end
      axi.awid = 4'd6; axi.awaddr = 32'd32; axi.awlen = 8'd3; axi.awsize = 3'd3;
      axi.awburst = 2'd1; axi.awuser = 4'd5; axi.awvalid = 1'b1;
      for (int c = 0; c < 50 && !axi.awready; c++) begin @(posedge clk); #1; end
      chk("rst_aw_wait", axi.awready, 1);
      @(posedge clk); #1;
      axi.awvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         axi.wvalid = 1'b1; axi.wdata = dq[i]; axi.wstrb = 8'hFF; axi.wlast = 1'b0;
         @(posedge clk); #1;
      end
      axi.wvalid = 1'b0;
      chk("mid_wready", axi.wready, 1);
      #2 rst_n = 1'b0;
      #1;
      chk_idle_outputs("mid_rst");
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      chk_mem("mid_rst_mem");
      rst_n = 1'b1;
      chk("rel_pre", axi.awready, 0);
      @(posedge clk); #1;
      chk("rel_awready", axi.awready, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
